spi_peripheral_tx: RTL and testbench
====================================

Name: spi_peripheral_tx

Overview:
SPI mode-0 peripheral (target) endpoint: the opposite end of the SPI controller that drives cs and samples miso.
- Samples external sclk/cs_n/mosi into the system clock domain.
- Shifts bytes out on miso, MSB first, from a one-entry transmit holding buffer fed by a valid/ready handshake.
- Captures mosi bytes and presents them as one-cycle rx_valid pulses.
- Sits at the chip boundary on the uio pins, alongside the controller-side driver.

Parameters:
DATA_W, 8, bits per SPI word.
SYNC_STAGES, 2, flip-flop synchronizer depth for sclk, cs_n and mosi (minimum 2).
DEFAULT_BYTE, 8'hFF, word shifted out when no transmit data is buffered (underrun).

Ports:
clk  in  1  system clock; must be at least 8x the sclk frequency.
rst_n  in  1  synchronous, active-low reset.
sclk  in  1  SPI serial clock, asynchronous to clk; idles low (CPOL=0).
cs_n  in  1  SPI chip select, active low, asynchronous.
mosi  in  1  serial data from the controller.
miso  out  1  serial data to the controller.
miso_oe  out  1  miso output enable; drives uio_oe for the miso pin.
tx_data  in  DATA_W  next word to transmit.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  holding buffer is empty; a word is accepted when tx_valid and tx_ready are both high.
rx_data  out  DATA_W  last complete received word; held until the next word completes.
rx_valid  out  1  one-clk pulse when rx_data updates.
busy  out  1  a transaction is in progress (synchronized cs_n is low).
tx_underrun  out  1  one-clk pulse when a word starts with the buffer empty.

Behaviour:
Synchronous reset (rst_n low at a clk edge):
- miso=0, miso_oe=0, rx_data=0, rx_valid=0, busy=0, tx_underrun=0, tx_ready=1.
- Holding buffer is emptied, bit counter is cleared, FSM goes to WAIT_IDLE.

Input synchronization and edge detection:
- sclk, cs_n and mosi each pass through SYNC_STAGES flops.
- Edge detectors act on the synchronized sclk and cs_n; all decisions use synchronized values only.

FSM states:
- WAIT_IDLE: ignore everything until synced cs_n is seen high, then go to IDLE. Entered after reset, so a reset mid-transfer never joins a transaction part-way.
- IDLE: miso_oe=0, busy=0. On a synced cs_n falling edge go to LOAD.
- LOAD (one cycle): load the shift register from the holding buffer if it is full and mark the buffer empty. If the buffer is empty, load DEFAULT_BYTE and pulse tx_underrun. Drive miso from the MSB, set miso_oe=1 and busy=1, set bitcnt=0, go to SHIFT.
- SHIFT:
  - On a synced sclk rising edge: shift mosi into rx_shift (MSB first) and increment bitcnt.
  - On a synced sclk falling edge with bitcnt between 1 and DATA_W-1: present the next tx bit on miso.
  - When bitcnt reaches DATA_W on a rising edge: in the following cycle, rx_data is updated from rx_shift, rx_valid pulses for exactly one clk, and bitcnt wraps to 0.
  - On the next synced sclk falling edge after a wrap: perform a back-to-back reload using the same rules as LOAD (buffer word, or DEFAULT_BYTE plus tx_underrun), and miso shows the new MSB.
- Any state: a synced cs_n rising edge returns the FSM to IDLE within one cycle.
  - miso_oe=0 and busy=0.
  - A partial rx word is discarded: no rx_valid, rx_data unchanged.
  - Transmit data already loaded into the shift register is lost; the holding buffer is untouched.

Transmit handshake:
- tx_ready = !buffer_full, registered.
- If a handshake and a LOAD/reload happen in the same cycle while the buffer is empty: the load uses DEFAULT_BYTE (no bypass), and the new word is stored for the next word.

Other rules:
- A cs_n low pulse with no sclk edges produces no rx_valid but still consumes the buffered word.
- rx_valid has no backpressure; the consumer must take rx_data within DATA_W sclk periods.
- Latency: rx_valid occurs SYNC_STAGES+2 clk cycles after the 8th pin-level sclk rising edge.

Decomposition:
- Package spi_pkg: DATA_W default; DEFAULT_BYTE; FSM state enum (WAIT_IDLE, IDLE, LOAD, SHIFT); constants SPI_CPOL=0 and SPI_CPHA=0.
- Sub-module spi_sync_edge: SYNC_STAGES synchronizer with registered rise/fall pulse outputs. One instance each for sclk and cs_n; mosi uses the synchronizer only.

Test Plan:
- Reset with cs_n high, then buffer 8'hA5 and run one 8-bit transfer with mosi=8'h3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; one rx_valid pulse; tx_ready returns to 1 at LOAD.
- Buffer 8'h81, then 8'h7E via the handshake during the first word, and run 16 sclk in one cs_n frame -> miso gives 0x81 then 0x7E; two rx_valid pulses; no tx_underrun.
- Start a transfer with the buffer empty -> miso gives 8'hFF; one tx_underrun pulse at LOAD.
- Raise cs_n after 5 sclk edges with mosi=8'hFF -> no rx_valid; rx_data keeps its previous value; miso_oe=0 and busy=0 within SYNC_STAGES+2 clk.
- Assert rst_n low mid-word (cs_n still low), release, finish the frame -> no rx_valid and miso_oe=0 until cs_n goes high then low; the next frame works normally.
- Run sclk at clk/8 with random sclk-to-clk phase over 100 random words -> every word is received and transmitted bit-exact.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared constants and types for the SPI mode-0 peripheral.
//            Holds the default word width, the underrun fill byte, the SPI
//            mode constants and the peripheral FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int         SPI_DATA_W       = 8;
    localparam logic [7:0] SPI_DEFAULT_BYTE = 8'hFF;

    // Mode 0: sclk idles low, data is sampled on the rising edge and
    // changed on the falling edge.
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        LOAD      = 2'd2,
        SHIFT     = 2'd3
    } spi_state_e;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Multi-flop synchronizer for an asynchronous pin, followed by an
//            edge detector working on the synchronized level.
// Ports    : clk, rst_n  - system clock, synchronous active-low reset
//            din         - asynchronous input pin
//            sync        - synchronized level
//            rise, fall  - one-cycle pulses on synchronized edges
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2    // must be at least 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // The chain resets low. For cs_n this means a pin that is already low at
    // reset release produces no falling edge, so a transfer in progress is
    // never joined part-way.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    // Both terms come straight from flops, so the pulses are glitch-free.
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_peripheral_tx.sv
`default_nettype none
// ============================================================================
// Module   : spi_peripheral_tx
// Purpose  : SPI mode-0 peripheral endpoint. Oversamples sclk/cs_n/mosi in the
//            clk domain, shifts a buffered word out on miso (MSB first) and
//            delivers received mosi words as rx_valid pulses.
// Ports    : clk, rst_n          - system clock, synchronous active-low reset
//            sclk, cs_n, mosi    - asynchronous SPI pins from the controller
//            miso, miso_oe       - serial data out and its pad enable
//            tx_data/valid/ready - one-entry transmit holding buffer
//            rx_data, rx_valid   - last received word and its update pulse
//            busy                - transaction in progress
//            tx_underrun         - word started with an empty buffer
// Revision : 1.0 - initial release
// ============================================================================
module spi_peripheral_tx
    import spi_pkg::*;
#(
    parameter int                DATA_W       = SPI_DATA_W,
    parameter int                SYNC_STAGES  = 2,
    parameter logic [DATA_W-1:0] DEFAULT_BYTE = SPI_DEFAULT_BYTE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              tx_underrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sclk),
        .sync  (sclk_s),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cs_n),
        .sync  (cs_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // mosi goes through the same depth as sclk so that the synchronized data
    // bit is aligned with the synchronized rising edge that samples it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
        end
    end
    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    // Only the edges of sclk drive decisions; the level itself is not needed.
    logic unused_sclk_level;
    assign unused_sclk_level = sclk_s;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    spi_state_e state, state_next;

    logic [CNT_W-1:0]  bitcnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] buf_data;
    logic              buf_full;
    logic              reload_pending;
    logic              underrun_pending;
    logic              load_now;
    logic              shift_tx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            WAIT_IDLE: if (cs_s)    state_next = IDLE;
            IDLE:      if (cs_fall) state_next = LOAD;
            LOAD:                   state_next = SHIFT;
            SHIFT:                  state_next = SHIFT;
            default:                state_next = WAIT_IDLE;
        endcase
        // Deselect aborts from anywhere.
        if (cs_rise) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        miso_oe  = (state == LOAD) || (state == SHIFT);
        busy     = (state == LOAD) || (state == SHIFT);
        load_now = (state == LOAD) ||
                   ((state == SHIFT) && sclk_fall && reload_pending && !cs_rise);
        shift_tx = (state == SHIFT) && sclk_fall &&
                   (bitcnt != '0) && (bitcnt < CNT_W'(DATA_W));
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_shift         <= '0;
            rx_shift         <= '0;
            rx_data          <= '0;
            rx_valid         <= 1'b0;
            tx_underrun      <= 1'b0;
            bitcnt           <= '0;
            buf_data         <= '0;
            buf_full         <= 1'b0;
            reload_pending   <= 1'b0;
            underrun_pending <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            // Holding buffer: a load drains it; a handshake can only occur
            // while it is empty, so the two never collide. A word accepted in
            // the same cycle as a load is kept for the following word.
            if (load_now && buf_full) begin
                buf_full <= 1'b0;
            end else if (tx_valid && !buf_full) begin
                buf_full <= 1'b1;
                buf_data <= tx_data;
            end

            if (load_now) begin
                tx_shift       <= buf_full ? buf_data : DEFAULT_BYTE;
                reload_pending <= 1'b0;
                if (state == LOAD) begin
                    tx_underrun      <= !buf_full;
                    underrun_pending <= 1'b0;
                end else begin
                    // A back-to-back reload happens on the trailing sclk edge
                    // of the previous word, before it is known whether the
                    // controller will clock another word at all. The underrun
                    // is reported only once that word really starts.
                    underrun_pending <= !buf_full;
                end
            end else if (shift_tx) begin
                tx_shift <= tx_shift << 1;
            end

            if (state == LOAD) begin
                bitcnt <= '0;
            end else if (state == SHIFT) begin
                if (bitcnt == CNT_W'(DATA_W)) begin
                    bitcnt         <= '0;
                    rx_data        <= rx_shift;
                    rx_valid       <= 1'b1;
                    reload_pending <= 1'b1;
                end else if (sclk_rise) begin
                    rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                    bitcnt   <= bitcnt + CNT_W'(1);
                    if (underrun_pending) begin
                        tx_underrun      <= 1'b1;
                        underrun_pending <= 1'b0;
                    end
                end
            end
        end
    end

    assign miso     = tx_shift[DATA_W-1];
    assign tx_ready = ~buf_full;

endmodule : spi_peripheral_tx
`default_nettype wire

// File: tb/tb_spi_peripheral_tx.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module   : tb_spi_peripheral_tx
// Purpose  : Scoreboard bench for spi_peripheral_tx. Stimulus pushes expected
//            rx words and miso words into queues; independent monitors pop
//            and compare when the DUT presents rx_valid or a full miso word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_peripheral_tx;

    localparam int SS    = 2;
    localparam int HALF  = 40;   // sclk half period: clk/8

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       sclk     = 1'b0;
    logic       cs_n     = 1'b1;
    logic       mosi     = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun;
    logic [7:0] rx_data;

    int checks   = 0;
    int failures = 0;
    int rxv_cnt  = 0;
    int und_cnt  = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    spi_peripheral_tx #(
        .DATA_W       (8),
        .SYNC_STAGES  (SS),
        .DEFAULT_BYTE (8'hFF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // rx monitor: pops one expected word per rx_valid pulse.
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            rxv_cnt++;
            if (exp_rx.size() == 0) fail_now("rx_unexpected_valid");
            else chk("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
        end
        if (rst_n && tx_underrun) und_cnt++;
    end

    // miso monitor: samples on sclk rising edges like a mode-0 controller.
    int         tx_nb  = 0;
    logic [7:0] tx_acc = 8'h00;
    always @(posedge sclk or posedge cs_n) begin
        if (cs_n) begin
            tx_nb = 0;
        end else if (miso_oe) begin
            tx_acc = {tx_acc[6:0], miso};
            tx_nb++;
            if (tx_nb == 8) begin
                tx_nb = 0;
                if (exp_tx.size() == 0) fail_now("miso_unexpected_word");
                else chk("miso_word", {24'h0, tx_acc}, {24'h0, exp_tx.pop_front()});
            end
        end
    end

    task automatic push_tx(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            fail_now("tx_ready_timeout");
        end else begin
            @(negedge clk);
        end
        tx_valid = 1'b0;
    endtask

    // One cs_n frame of nbits sclk periods; bits are sent MSB first.
    // rst_at >= 0 pulses rst_n before that bit's rising edge.
    task automatic run_frame(input int nbits, input logic [15:0] bits,
                             input int rst_at, input bit expect_active);
        #(real'($urandom_range(1, 98)) / 10.0);
        cs_n = 1'b0;
        mosi = bits[nbits-1];
        #(2*HALF);
        if (expect_active) begin
            chk("busy_in_frame", {31'h0, busy}, 32'h1);
            chk("oe_in_frame", {31'h0, miso_oe}, 32'h1);
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
            if (i < nbits - 1) mosi = bits[nbits-2-i];
            #HALF;
        end
        if (rst_at >= 0) begin
            chk("oe_after_reset", {31'h0, miso_oe}, 32'h0);
            chk("busy_after_reset", {31'h0, busy}, 32'h0);
        end
        cs_n = 1'b1;
        repeat (SS + 2) @(negedge clk);
        chk("oe_after_cs_high", {31'h0, miso_oe}, 32'h0);
        chk("busy_after_cs_high", {31'h0, busy}, 32'h0);
        #60;
    endtask

    initial begin
        int rx0, un0;
        logic [7:0] d, m;

        // Reset with cs_n high.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_miso", {31'h0, miso}, 32'h0);
        chk("rst_miso_oe", {31'h0, miso_oe}, 32'h0);
        chk("rst_rx_data", {24'h0, rx_data}, 32'h0);
        chk("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_underrun", {31'h0, tx_underrun}, 32'h0);
        chk("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Single word: tx A5, rx 3C.
        rx0 = rxv_cnt; un0 = und_cnt;
        push_tx(8'hA5);
        exp_tx.push_back(8'hA5);
        exp_rx.push_back(8'h3C);
        chk("tx_ready_full", {31'h0, tx_ready}, 32'h0);
        fork
            run_frame(8, 16'h003C, -1, 1'b1);
            begin
                wait (cs_n == 1'b0);
                repeat (6) @(negedge clk);
                chk("tx_ready_after_load", {31'h0, tx_ready}, 32'h1);
            end
        join
        chk("t1_rx_valid_count", rxv_cnt - rx0, 1);
        chk("t1_underruns", und_cnt - un0, 0);

        // Back-to-back: 81 buffered, 7E handed over during the first word.
        rx0 = rxv_cnt; un0 = und_cnt;
        push_tx(8'h81);
        exp_tx.push_back(8'h81);
        exp_tx.push_back(8'h7E);
        exp_rx.push_back(8'h5A);
        exp_rx.push_back(8'hC3);
        fork
            run_frame(16, 16'h5AC3, -1, 1'b1);
            begin
                #200;
                push_tx(8'h7E);
            end
        join
        chk("t2_rx_valid_count", rxv_cnt - rx0, 2);
        chk("t2_underruns", und_cnt - un0, 0);

        // Empty buffer: default byte and one underrun.
        rx0 = rxv_cnt; un0 = und_cnt;
        exp_tx.push_back(8'hFF);
        exp_rx.push_back(8'h12);
        run_frame(8, 16'h0012, -1, 1'b1);
        chk("t3_rx_valid_count", rxv_cnt - rx0, 1);
        chk("t3_underruns", und_cnt - un0, 1);

        // Abort after 5 sclk: partial word discarded.
        rx0 = rxv_cnt;
        run_frame(5, 16'h001F, -1, 1'b1);
        chk("t4_rx_valid_count", rxv_cnt - rx0, 0);
        chk("t4_rx_data_held", {24'h0, rx_data}, 32'h12);

        // Reset mid-word with cs_n held low.
        rx0 = rxv_cnt;
        run_frame(8, 16'h00F0, 3, 1'b1);
        chk("t5_rx_valid_count", rxv_cnt - rx0, 0);
        chk("t5_rx_data_reset", {24'h0, rx_data}, 32'h0);

        // Next frame after the reset works normally.
        rx0 = rxv_cnt;
        push_tx(8'hC3);
        exp_tx.push_back(8'hC3);
        exp_rx.push_back(8'h99);
        run_frame(8, 16'h0099, -1, 1'b1);
        chk("t6_rx_valid_count", rxv_cnt - rx0, 1);

        // Random words with random sclk-to-clk phase.
        rx0 = rxv_cnt;
        for (int k = 0; k < 100; k++) begin
            d = 8'($urandom);
            m = 8'($urandom);
            push_tx(d);
            exp_tx.push_back(d);
            exp_rx.push_back(m);
            run_frame(8, {8'h00, m}, -1, 1'b0);
        end
        chk("t7_rx_valid_count", rxv_cnt - rx0, 100);

        #200;
        chk("exp_rx_drained", exp_rx.size(), 0);
        chk("exp_tx_drained", exp_tx.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule : tb_spi_peripheral_tx
`default_nettype wire
